spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- SPI mode-0 target that models the ADC end of the link driven by our conversion controller.
- Serves one sample per chip-select frame on miso: LEAD_ZEROS null bits, then DATA_W data bits, MSB first.
- Samples are supplied through a one-deep valid/ready holding register.
- cs_n and sck are asynchronous to clk; both are synchronised and edge-detected internally.
- Used as an on-chip loopback target and as the bench model for the controller.

Parameters:
- DATA_W, 12: sample width in bits.
- LEAD_ZEROS, 2: null bits sent before the sample MSB.
- SYNC_STAGES, 2: synchroniser depth on cs_n and sck (minimum 2).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- sample_in, input, DATA_W: sample offered to the holding register.
- sample_valid, input, 1: sample_in valid.
- sample_ready, output, 1: holding register empty and able to accept.
- cs_n, input, 1: chip select from the controller, active low.
- sck, input, 1: SPI clock from the controller, idle low.
- miso, output, 1: serial data to the controller.
- miso_oe, output, 1: miso drive enable; high while a frame is active or done.
- frame_done, output, 1: one-cycle pulse when all N = LEAD_ZEROS+DATA_W bits have been clocked.
- frame_abort, output, 1: one-cycle pulse when cs_n rises before the frame completes.
- stale, output, 1: the current or last frame resent the previous sample.

Behaviour:
- Reset values:
  - Outputs: miso=0, miso_oe=0, frame_done=0, frame_abort=0, stale=0, sample_ready=1.
  - Internal: hold register empty, last-sample register 0, state IDLE.
  - Synchroniser flops: cs_n chain resets to 0, sck chain resets to 0. A cs_n held low through reset therefore starts no frame; a high level after reset is seen as a rise and ignored in IDLE.
- Edge detection:
  - Falling or rising edges are detected from the last two synchroniser stages.
  - Edge-to-action latency is SYNC_STAGES+1 clk.
  - sck high and low phases must each be at least SYNC_STAGES+2 clk.
- Holding register:
  - Accepts when sample_valid && sample_ready.
  - sample_ready = !hold_full.
- States:
  - IDLE:
    - miso=0, miso_oe=0.
    - On a cs_n fall: choose the sample (rules below), load shift[N-1:0] = {LEAD_ZEROS'b0, sample}, bit_cnt=0, go to SHIFT.
  - Sample selection at frame start:
    - hold_full: take the held sample, clear hold_full, stale=0.
    - Else if an accept occurs in the same cycle: bypass sample_in directly, hold stays empty, stale=0.
    - Else: use the last-sample register, stale=1.
    - The chosen sample is always copied into the last-sample register.
  - SHIFT:
    - miso_oe=1, miso=shift[N-1].
    - On an sck fall: shift left by 1, filling 0.
    - On an sck rise: bit_cnt++. When bit_cnt reaches N, pulse frame_done and go to DONE.
    - The first bit is valid before the first sck rise, since it is presented at the cs_n fall.
    - A cs_n rise in SHIFT pulses frame_abort, drives miso=0, and goes to IDLE. The consumed sample is not restored.
  - DONE:
    - miso_oe=1, miso=0. All sck edges are ignored.
    - A cs_n rise goes to IDLE with no pulse.
- Simultaneous sck and cs_n edges in the same cycle: the cs_n rise takes priority and the sck edge is ignored.
- stale holds its value until the next frame start.
- Asynchronous reset mid-frame: immediate return to reset values; the bit position is lost.

Test Plan:
1. Basic frame, DATA_W=12, LEAD_ZEROS=2:
   - Stimulus: load 0xA5C, cs_n low, 14 sck pulses (half-period 8 clk).
   - Required: master samples 00_1010_0101_1100; frame_done pulses once, 3 clk after the 14th rise; stale=0; sample_ready=1 afterwards.
2. Stale resend:
   - Stimulus: second frame with no new sample.
   - Required: 0xA5C resent, stale=1.
   - Then load 0x123 and run a third frame: required 0x123, stale=0.
3. Bypass:
   - Stimulus: sample_valid with 0x3FF in the same cycle the cs_n fall is detected, hold empty.
   - Required: frame carries 0x3FF, stale=0, sample_ready stays 1.
4. Abort:
   - Stimulus: cs_n rises after 5 sck pulses.
   - Required: frame_abort one pulse, no frame_done, miso_oe=0 within 4 clk.
   - Next frame sends the last sample with stale=1.
5. Extra clocks:
   - Stimulus: 16 sck pulses in one frame.
   - Required: frame_done once, at the 14th rise; miso=0 on pulses 15–16.
6. Reset mid-frame:
   - Stimulus: assert reset at bit 7 with cs_n held low, release.
   - Required: all outputs at reset values, no frame starts until cs_n goes high then low, and the next frame is complete and correct.

Source files
------------

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 target modelling the ADC end of the conversion link.
// Each chip-select frame sends LEAD_ZEROS null bits followed by a DATA_W-bit sample, MSB first.
// Ports:
//   clk, reset                   system clock and asynchronous active-high reset
//   sample_in/valid/ready        one-deep holding register for the next sample
//   cs_n, sck                    asynchronous SPI inputs, synchronised internally
//   miso, miso_oe                serial data out and its drive enable
//   frame_done, frame_abort      one-cycle completion / early-deselect pulses
//   stale                        current or last frame resent the previous sample
module spi_adc_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LEAD_ZEROS  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              cs_n,
  input  logic              sck,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              stale
);

  localparam int unsigned N     = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  // Bit SYNC_STAGES is a history flop behind the last synchroniser stage.
  logic [SYNC_STAGES:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES:0] sck_sync_q, sck_sync_d;
  logic [N-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                stale_q, stale_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_abort_q, frame_abort_d;

  logic                cs_fall, cs_rise, sck_fall, sck_rise;
  logic                accept;
  logic [DATA_W-1:0]   sel_sample;

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-1:0], cs_n};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-1:0], sck};
    cs_fall    =  cs_sync_q[SYNC_STAGES]  & ~cs_sync_q[SYNC_STAGES-1];
    cs_rise    = ~cs_sync_q[SYNC_STAGES]  &  cs_sync_q[SYNC_STAGES-1];
    sck_fall   =  sck_sync_q[SYNC_STAGES] & ~sck_sync_q[SYNC_STAGES-1];
    sck_rise   = ~sck_sync_q[SYNC_STAGES] &  sck_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    last_d        = last_q;
    stale_d       = stale_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    sel_sample    = last_q;
    accept        = sample_valid && !hold_full_q;

    if (accept) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          // A same-cycle accept bypasses the holding register, leaving it empty.
          if (hold_full_q) begin
            sel_sample  = hold_q;
            hold_full_d = 1'b0;
            stale_d     = 1'b0;
          end else if (accept) begin
            sel_sample  = sample_in;
            hold_full_d = 1'b0;
            stale_d     = 1'b0;
          end else begin
            sel_sample  = last_q;
            stale_d     = 1'b1;
          end
          last_d    = sel_sample;
          shift_d   = N'(sel_sample);
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n rise wins over any sck edge seen in the same cycle.
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          state_d       = IDLE;
        end else if (sck_fall) begin
          shift_d = {shift_q[N-2:0], 1'b0};
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cs_sync_q     <= '0;
      sck_sync_q    <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      last_q        <= '0;
      stale_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_sync_q     <= cs_sync_d;
      sck_sync_q    <= sck_sync_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      last_q        <= last_d;
      stale_q       <= stale_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso         = (state_q == SHIFT) ? shift_q[N-1] : 1'b0;
  assign miso_oe      = (state_q != IDLE);
  assign sample_ready = !hold_full_q;
  assign stale        = stale_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
module tb_spi_adc_responder;

  localparam int DW = 12;
  localparam int LZ = 2;
  localparam int N  = DW + LZ;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          cs_n;
  logic          sck;
  logic          miso;
  logic          miso_oe;
  logic          frame_done;
  logic          frame_abort;
  logic          stale;

  always #5 clk = ~clk;

  spi_adc_responder #(
    .DATA_W     (DW),
    .LEAD_ZEROS (LZ),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .cs_n        (cs_n),
    .sck         (sck),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .stale       (stale)
  );

  typedef struct packed {
    logic [N-1:0] bits;
    logic         stale;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_checks  = 0;
  int           n_errors  = 0;
  int           cyc       = 0;
  int           rise_cyc  = 0;
  int           done_cnt  = 0;
  int           abort_cnt = 0;
  logic [N-1:0] cap       = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: pops the expected frame and compares what the master sampled.
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      check("done_latency", cyc - rise_cyc, 3);
      check("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("frame_bits", cap, mon_e.bits);
        check("frame_stale", stale, mon_e.stale);
      end
    end
    if (frame_abort) abort_cnt++;
  end

  task automatic sck_pulse(input int p);
    if (p <= N) cap = {cap[N-2:0], miso};
    else check("extra_miso", miso, 0);
    sck      = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_sample(input logic [DW-1:0] v);
    check("ready_before_load", sample_ready, 1);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_after_load", sample_ready, 0);
  endtask

  task automatic frame(input int pulses, input logic complete, input logic [DW-1:0] exp_data,
                       input logic exp_stale, input logic bypass, input logic [DW-1:0] bp);
    int   d0, a0;
    exp_t e;
    d0 = done_cnt;
    a0 = abort_cnt;
    if (complete) begin
      e.bits  = N'(exp_data);
      e.stale = exp_stale;
      sb.push_back(e);
    end
    cap  = '0;
    cs_n = 1'b0;
    if (bypass) begin
      // Valid lands on the edge where the cs_n fall is acted upon.
      repeat (2) @(negedge clk);
      sample_in    = bp;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check("bypass_ready", sample_ready, 1);
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    check("oe_active", miso_oe, 1);
    for (int p = 1; p <= pulses; p++) sck_pulse(p);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("oe_idle", miso_oe, 0);
    check("done_count", done_cnt - d0, {31'd0, complete});
    check("abort_count", abort_cnt - a0, {31'd0, !complete});
    check("stale_after", stale, exp_stale);
    check("ready_after", sample_ready, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_oe"}, miso_oe, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_abort"}, frame_abort, 0);
    check({tag, "_stale"}, stale, 0);
    check({tag, "_ready"}, sample_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset        = 1'b1;
    cs_n         = 1'b1;
    sck          = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_oe_after_rst", miso_oe, 0);

    // Basic frame
    push_sample(12'hA5C);
    frame(14, 1'b1, 12'hA5C, 1'b0, 1'b0, '0);

    // Stale resend, then fresh sample
    frame(14, 1'b1, 12'hA5C, 1'b1, 1'b0, '0);
    push_sample(12'h123);
    frame(14, 1'b1, 12'h123, 1'b0, 1'b0, '0);

    // Bypass on the frame-start cycle
    frame(14, 1'b1, 12'h3FF, 1'b0, 1'b1, 12'h3FF);

    // Abort after 5 pulses, then stale resend of the last sample
    frame(5, 1'b0, '0, 1'b1, 1'b0, '0);
    frame(14, 1'b1, 12'h3FF, 1'b1, 1'b0, '0);

    // Extra clocks in one frame
    push_sample(12'h5A6);
    frame(16, 1'b1, 12'h5A6, 1'b0, 1'b0, '0);

    // Reset mid-frame with cs_n held low
    push_sample(12'h7E1);
    d0   = done_cnt;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int p = 1; p <= 7; p++) sck_pulse(p);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_outputs("postrst");
    sck_pulse(99);
    sck_pulse(99);
    check("postrst_oe", miso_oe, 0);
    check("postrst_no_done", done_cnt - d0, 0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postrst_idle_oe", miso_oe, 0);
    push_sample(12'h456);
    frame(14, 1'b1, 12'h456, 1'b0, 1'b0, '0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
